// File: rtl/pipeline_defs.sv
// Shared pipeline definitions.
// Memory access encoding used by controller, EX/MEM and dm_unit.
package pipeline_defs;

    localparam logic [2:0] MEM_W  = 3'd0;
    localparam logic [2:0] MEM_H  = 3'd1;
    localparam logic [2:0] MEM_HU = 3'd2;
    localparam logic [2:0] MEM_B  = 3'd3;
    localparam logic [2:0] MEM_BU = 3'd4;

    localparam logic [31:0] DM_BASE  = 32'h0;
    localparam int          DM_WORDS = 3072;

endpackage

// File: rtl/dm_lane_logic.sv
// Byte-lane steering for data memory accesses.
// Store enables/replication, alignment check, load extension.
module dm_lane_logic
    import pipeline_defs::*;
(
    input  logic [2:0]  mem_op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic        misalign_o,
    output logic [31:0] ldata_o
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    // Pick the addressed halfword and byte out of the read word
    always_comb begin
        half     = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
        byte_sel = 8'h00;
        case (lane_i)
            2'd0:    byte_sel = rword_i[7:0];
            2'd1:    byte_sel = rword_i[15:8];
            2'd2:    byte_sel = rword_i[23:16];
            default: byte_sel = rword_i[31:24];
        endcase
    end

    // Decode access size into enables, store data and load result
    always_comb begin
        be_o       = 4'hF;
        wword_o    = wdata_i;
        misalign_o = 1'b0;
        ldata_o    = rword_i;
        case (mem_op_i)
            MEM_H, MEM_HU: begin
                be_o       = lane_i[1] ? 4'b1100 : 4'b0011;
                wword_o    = {2{wdata_i[15:0]}};
                misalign_o = lane_i[0];
                ldata_o    = (mem_op_i == MEM_H) ?
                             {{16{half[15]}}, half} :
                             {16'h0000, half};
            end
            MEM_B, MEM_BU: begin
                be_o    = 4'b0001 << lane_i;
                wword_o = {4{wdata_i[7:0]}};
                ldata_o = (mem_op_i == MEM_B) ?
                          {{24{byte_sel[7]}}, byte_sel} :
                          {24'h000000, byte_sel};
            end
            // W and reserved encodings behave as a full word
            default: begin
                misalign_o = |lane_i;
            end
        endcase
    end

endmodule

// File: rtl/dm_unit.sv
// MEM-stage data memory: byte-lane stores, extended loads.
// Combinational read, stores commit on the rising edge.
module dm_unit
    import pipeline_defs::*;
#(
    parameter int DEPTH_WORDS = DM_WORDS,
    parameter int LOG_EN      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        mem_write,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          in_range;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic          misalign;
    logic [31:0]   ldata;
    logic [31:0]   merged_d;
    logic          we;

    dm_lane_logic u_lane (
        .mem_op_i   (mem_op),
        .lane_i     (addr[1:0]),
        .wdata_i    (wdata),
        .rword_i    (rword),
        .be_o       (be),
        .wword_o    (wword),
        .misalign_o (misalign),
        .ldata_o    (ldata)
    );

    // Range check, word read and byte-lane merge of store data
    always_comb begin
        off      = addr - DM_BASE;
        in_range = off < LIMIT;
        idx      = off[AW+1:2];
        rword    = in_range ? mem_q[idx] : 32'h0;
        addr_err = !in_range || misalign;
        rdata    = addr_err ? 32'h0 : ldata;
        for (int i = 0; i < 4; i++) begin
            merged_d[i*8 +: 8] = be[i] ? wword[i*8 +: 8]
                                       : rword[i*8 +: 8];
        end
        // An unknown enable must never look like a write
        we = (mem_write == 1'b1) && !addr_err;
    end

    // Storage: synchronous clear, otherwise commit merged word
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (we) begin
            mem_q[idx] <= merged_d;
        end
    end

`ifndef SYNTHESIS
    if (LOG_EN != 0) begin : g_log
        // Trace each committed store with its merged word
        always_ff @(posedge clk) begin
            if (!reset && we) begin
                $display("%0t@%08h: *%08h <= %08h", $time, pc,
                         {addr[31:2], 2'b00}, merged_d);
            end
        end
    end
`endif

endmodule
